// File: rtl/core_ex_muldiv.sv
// rtl/core_ex_muldiv.sv - iterative RV32M multiply/divide sequencer for the execute stage
//
// Accepts one operation at a time, runs a 32-step shift-add (multiply) or
// restoring shift-subtract (divide) loop, and holds the result until consumed.
//
// Ports:
//   clk        in   rising-edge clock
//   rest       in   asynchronous active-low reset
//   op_valid   in   request, sampled only while idle
//   op         in   funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   in1, in2   in   rs1 / rs2 operands, latched when the request is taken
//   flush      in   abandon the current operation (highest priority)
//   op_accept  in   EX has consumed the result
//   op_ready   out  result valid on out (high exactly while DONE)
//   out        out  registered result
//   busy       out  high while calculating or holding a result
module core_ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rest,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush,
  input  logic            op_accept,
  output logic            op_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  // hi/lo: upper/lower product halves for multiply;
  // partial remainder / dividend-shifting-into-quotient for divide.
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] out_q, out_d;

  // ---------------- request decode (used only in IDLE) ----------------
  logic            is_div;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            res_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div   = op[2];
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && in1[XLEN-1];
    b_neg    = b_signed && in2[XLEN-1];
    a_mag    = a_neg ? (~in1 + 1'b1) : in1;
    b_mag    = b_neg ? (~in2 + 1'b1) : in2;
    // Remainder follows the dividend's sign; everything else is sign(a)^sign(b).
    res_neg  = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);

    div_zero = is_div && (in2 == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (in1 == MIN_NEG) && (in2 == '1);
    special  = div_zero || div_ovf;
    // op[1] separates REM/REMU from DIV/DIVU.
    if (div_zero) begin
      special_res = op[1] ? in1 : '1;
    end else begin
      special_res = op[1] ? '0 : MIN_NEG;
    end
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] trial_sub;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier LSB is set,
    // then shift the 64-bit {hi,lo} right by one.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    // Divide: shift in next dividend bit, subtract divisor if it fits.
    trial     = {hi_q, lo_q[XLEN-1]};
    ge        = (trial >= {1'b0, dvs_q});
    // When ge holds the true difference is below the divisor, so the low
    // XLEN bits of the subtraction are exact.
    trial_sub = trial[XLEN-1:0] - dvs_q;
    if (op_q[2]) begin
      step_hi = ge ? trial_sub : trial[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // ---------------- sign fixup and result select ----------------
  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0]   dv_sel;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod   = {step_hi, step_lo};
    prod_f = neg_q ? (~prod + 1'b1) : prod;
    dv_sel = op_q[1] ? step_hi : step_lo;
    if (op_q[2]) begin
      fix_res = neg_q ? (~dv_sel + 1'b1) : dv_sel;
    end else if (op_q == OP_MUL) begin
      fix_res = prod_f[XLEN-1:0];
    end else begin
      fix_res = prod_f[2*XLEN-1:XLEN];
    end
  end

  // ---------------- next-state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    out_d   = out_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            op_d  = op;
            neg_d = res_neg;
            cnt_d = '0;
            hi_d  = '0;
            dvs_d = is_div ? b_mag : a_mag;
            lo_d  = is_div ? a_mag : b_mag;
            if (special) begin
              state_d = S_DONE;
              out_d   = special_res;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          hi_d = step_hi;
          lo_d = step_lo;
          // Final step and result load share the same edge; counter saturates.
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
            out_d   = fix_res;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_DONE: begin
          if (op_accept) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      out_q   <= out_d;
    end
  end

  assign op_ready = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign out      = out_q;

endmodule

// File: tb/tb_core_ex_muldiv.sv
// tb/tb_core_ex_muldiv.sv - randomized self-checking bench for core_ex_muldiv
module tb_core_ex_muldiv;

  logic        clk;
  logic        rest;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        flush;
  logic        op_accept;
  logic        op_ready;
  logic [31:0] out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  core_ex_muldiv #(.XLEN(32)) dut (
    .clk       (clk),
    .rest      (rest),
    .op_valid  (op_valid),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .flush     (flush),
    .op_accept (op_accept),
    .op_ready  (op_ready),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      la, lb;
    logic [63:0] p;
    ia = a;
    ib = b;
    la = ia;
    lb = ib;
    case (o)
      3'd0: begin p = la * lb; return p[31:0]; end
      3'd1: begin p = la * lb; return p[63:32]; end
      3'd2: begin p = la * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return 0;
    if (b == 0) return 1;
    return (o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- cycle-level behavioural model ----------------
  // Tracks idle/busy/holding as plain flags and a countdown to result delivery.
  logic        m_busy, m_ready;
  logic [31:0] m_out, m_res;
  int          m_left;

  always @(posedge clk or negedge rest) begin
    if (!rest) begin
      m_busy  <= 0;
      m_ready <= 0;
      m_out   <= 0;
      m_res   <= 0;
      m_left  <= 0;
    end else if (flush) begin
      m_busy  <= 0;
      m_ready <= 0;
    end else if (!m_busy) begin
      if (op_valid) begin
        m_busy <= 1;
        if (is_special(op, in1, in2)) begin
          m_ready <= 1;
          m_out   <= ref_res(op, in1, in2);
        end else begin
          m_res  <= ref_res(op, in1, in2);
          m_left <= 32;
        end
      end
    end else if (!m_ready) begin
      if (m_left == 1) begin
        m_ready <= 1;
        m_out   <= m_res;
      end
      m_left <= m_left - 1;
    end else if (op_accept) begin
      m_ready <= 0;
      m_busy  <= 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_op_ready", {31'd0, op_ready}, {31'd0, m_ready});
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_out", out, m_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Presents a request and waits for op_ready, scrambling inputs after sampling.
  task automatic start_wait(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
    bit done;
    @(negedge clk);
    op_valid = 1;
    op = o;
    in1 = a;
    in2 = b;
    lat = 0;
    done = 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      op_valid = 0;
      op = 3'($urandom);
      in1 = $urandom;
      in2 = $urandom;
      if (op_ready) done = 1;
    end
    if (!done) begin
      errors++;
      $display("FAIL wait_op_ready actual=timeout expected=op_ready within 60 cycles");
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit lit_en, input logic [31:0] lit);
    int lat;
    start_wait(o, a, b, lat);
    chk("latency", lat, is_special(o, a, b) ? 1 : 33);
    if (lit_en) chk("result_literal", out, lit);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_ready", {31'd0, op_ready}, 32'd1);
    end
    op_accept = 1;
    @(negedge clk);
    op_accept = 0;
    chk("after_accept_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    rest = 0; op_valid = 0; op = 0; in1 = 0; in2 = 0; flush = 0; op_accept = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out", out, 32'd0);
    rest = 1;
    cmp_en = 1;

    // Pin the reference model with hand-computed values.
    chk("pin_mul",    ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulh",   ref_res(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("pin_mulhu",  ref_res(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("pin_mulhsu", ref_res(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div",    ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem",    ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    // Directed vectors.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 3, 1, 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 1, 32'h4000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 1, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 0, 1, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 0, 1, 32'd2);
    run_op(3'd4, 32'd5, 32'd0, 0, 1, 32'hFFFF_FFFF);
    run_op(3'd7, 32'h1234, 32'd0, 2, 1, 32'h1234);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'd0);

    // Flush at CALC cycle 10.
    @(negedge clk);
    op_valid = 1; op = 3'd0; in1 = 32'd9; in2 = 32'd9;
    @(negedge clk);
    op_valid = 0;
    repeat (10) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_ready", {31'd0, op_ready}, 32'd0);
    repeat (30) @(negedge clk);
    chk("flush_no_ready", {31'd0, op_ready}, 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 0, 1, 32'd12);

    // flush together with op_accept while holding a result.
    start_wait(3'd5, 32'd50, 32'd5, lat);
    chk("fa_latency", lat, 33);
    flush = 1; op_accept = 1;
    @(negedge clk);
    flush = 0; op_accept = 0;
    chk("fa_busy", {31'd0, busy}, 32'd0);
    chk("fa_ready", {31'd0, op_ready}, 32'd0);

    // Reset at CALC cycle 20.
    @(negedge clk);
    op_valid = 1; op = 3'd4; in1 = 32'd1000; in2 = 32'd3;
    @(negedge clk);
    op_valid = 0;
    repeat (20) @(negedge clk);
    rest = 0;
    #1;
    chk("mid_rst_ready", {31'd0, op_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_out", out, 32'd0);
    @(negedge clk);
    rest = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Randomized operations, biased toward divide corner cases.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      int          sel;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 15);
      else if (sel == 3) a = 32'h8000_0000;
      run_op(o, a, b, $urandom_range(0, 3), 0, 32'd0);
    end

    repeat (2) @(negedge clk);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
